// File: rtl/fp_pkg.sv
// Shared float32 helpers and capture FSM state encoding.
package fp_pkg;

    localparam int         FP_SIGN_BIT = 31;
    localparam int         FP_EXP_MSB  = 30;
    localparam int         FP_EXP_LSB  = 23;
    localparam int         FP_MAN_MSB  = 22;
    localparam logic [7:0] FP_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DRAIN
    } cap_state_t;

    // Exponent all ones with a non-zero mantissa; the sign is irrelevant.
    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX) && (x[FP_MAN_MSB:0] != '0);
    endfunction

    // Magnitude with the sign bit cleared; ordering of the remaining 31 bits
    // as an unsigned integer matches float magnitude ordering.
    function automatic logic [31:0] fp_abs(input logic [31:0] x);
        return x & ~(32'd1 << FP_SIGN_BIT);
    endfunction

endpackage

// File: rtl/fp_capture_ram.sv
// DEPTH x 32 capture memory: one write port, one registered read port.
module fp_capture_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Array write only; no reset so it can map onto a block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Output register loads only on a read and otherwise holds its word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fp_fir_capture_buffer.sv
// Captures a block of settled FIR float32 samples after the warm-up skip,
// tracks peak magnitude / NaN count, then replays the block on ready/valid.
module fp_fir_capture_buffer
    import fp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int SKIP  = 30,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          valid_in,
    input  logic [31:0]   data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [31:0]   peak,
    output logic [15:0]   nan_cnt
);

    localparam int              SW        = $clog2(SKIP + 2);
    localparam logic [SW-1:0]   SKIP_LAST = SW'(SKIP - 1);
    localparam logic [AW:0]     DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE_W     = (AW + 1)'(1);

    cap_state_t    state_q;
    logic [SW-1:0] skip_cnt_q;
    logic [AW:0]   wr_cnt_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   eff_len_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   peak_q;
    logic [15:0]   nan_cnt_q;

    logic [AW:0]   eff_len_d;
    logic [AW:0]   wr_cnt_inc_d;
    logic [AW:0]   rd_ptr_inc_d;
    logic          wr_en_d;
    logic          rd_en_d;
    logic          xfer_d;

    // Length clamp, memory strobes and the readback prefetch condition.
    always_comb begin
        eff_len_d    = ((len == '0) || (len > DEPTH_W)) ? DEPTH_W : len;
        wr_cnt_inc_d = wr_cnt_q + ONE_W;
        rd_ptr_inc_d = rd_ptr_q + ONE_W;
        wr_en_d      = (state_q == ST_CAPTURE) && valid_in;
        xfer_d       = out_valid_q && out_ready;
        // Fetch the next word whenever the output slot is empty or being drained.
        rd_en_d      = (state_q == ST_DRAIN) && (rd_ptr_q < eff_len_q) &&
                       (!out_valid_q || out_ready);
    end

    // Control FSM with counters, statistics and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            eff_len_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            peak_q      <= '0;
            nan_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        eff_len_q  <= eff_len_d;
                        skip_cnt_q <= '0;
                        wr_cnt_q   <= '0;
                        rd_ptr_q   <= '0;
                        peak_q     <= '0;
                        nan_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (valid_in) begin
                        skip_cnt_q <= skip_cnt_q + SW'(1);
                        if (skip_cnt_q == SKIP_LAST) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (valid_in) begin
                        wr_cnt_q <= wr_cnt_inc_d;
                        if (fp_is_nan(data_in)) begin
                            if (nan_cnt_q != 16'hFFFF) begin
                                nan_cnt_q <= nan_cnt_q + 16'd1;
                            end
                        end else if (fp_abs(data_in) > peak_q) begin
                            peak_q <= fp_abs(data_in);
                        end
                        if (wr_cnt_inc_d == eff_len_q) begin
                            state_q     <= ST_DRAIN;
                            rd_ptr_q    <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_en_d) begin
                        rd_ptr_q    <= rd_ptr_inc_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_ptr_inc_d == eff_len_q);
                    end else if (xfer_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (xfer_d && out_last_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    fp_capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_d),
        .waddr (wr_cnt_q[AW-1:0]),
        .wdata (data_in),
        .re    (rd_en_d),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (out_data)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign peak      = peak_q;
    assign nan_cnt   = nan_cnt_q;

endmodule

// File: tb/tb_fp_fir_capture_buffer.sv
// Directed bench for fp_fir_capture_buffer (DEPTH=16, SKIP=30).
module tb_fp_fir_capture_buffer;

    localparam int DEPTH = 16;
    localparam int SKIP  = 30;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          valid_in;
    logic [31:0]   data_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [31:0]   peak;
    logic [15:0]   nan_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   expv [16];

    always #5 clk = ~clk;

    fp_fir_capture_buffer #(
        .DEPTH (DEPTH),
        .SKIP  (SKIP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .peak      (peak),
        .nan_cnt   (nan_cnt)
    );

    // Float32 encoding of a small positive integer.
    function automatic logic [31:0] i2f(input int v);
        int          e;
        logic [31:0] m;
        e = 0;
        for (int b = 0; b < 31; b++) if (v[b]) e = b;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] v);
        valid_in = 1'b1;
        data_in  = v;
        step();
        valid_in = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    // Reads n words against expv; bp applies the ready pattern 1,0,0,1.
    task automatic drain(input int n, input bit bp, input string tag);
        logic [3:0] pat;
        int idx;
        int cyc;
        pat = 4'b1001;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            out_ready = bp ? pat[3 - (cyc % 4)] : 1'b1;
            chk({tag, ".done_low"}, 32'(done), 32'd0);
            if (!bp) chk({tag, ".no_gap"}, 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk($sformatf("%s.data[%0d]", tag, idx), out_data, expv[idx]);
                chk($sformatf("%s.last[%0d]", tag, idx), 32'(out_last), 32'(idx == n - 1));
                if (out_ready) idx++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, ".count"}, 32'(idx), 32'(n));
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
        chk({tag, ".valid_fall"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".done_once"}, 32'(done), 32'd0);
    endtask

    // Start, skip the warm-up, capture ascending values from base, replay.
    task automatic run_block(input logic [AW:0] l, input int base, input int n,
                             input bit glitch, input string tag);
        for (int k = 0; k < n; k++) expv[k] = i2f(base + k);
        do_start(l);
        chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
        for (int k = 0; k < SKIP; k++) feed(32'h7F7FFFFF);
        for (int k = 0; k < n + 2; k++) begin
            if (glitch && k == 2) begin
                start = 1'b1;
                len   = (AW + 1)'(2);
            end
            feed((k < n) ? expv[k] : 32'h7F7FFFFF);
            start = 1'b0;
        end
        chk({tag, ".peak"}, peak, expv[n - 1]);
        chk({tag, ".nan"}, 32'(nan_cnt), 32'd0);
        drain(n, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len       = '0;
        valid_in  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_last",  32'(out_last),  32'd0);
        chk("rst.out_data",  out_data,       32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.done",      32'(done),      32'd0);
        chk("rst.peak",      peak,           32'd0);
        chk("rst.nan",       32'(nan_cnt),   32'd0);
        rst = 1'b1;
        step();

        // Ramp 1.0..40.0, len 8: samples 31..38 kept, 39/40 arrive in DRAIN.
        do_start((AW + 1)'(8));
        chk("ramp.busy_rise", 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            feed(i2f(i));
            if (i == 38) begin
                chk("ramp.valid_lat1", 32'(out_valid), 32'd0);
                chk("ramp.peak", peak, 32'h42180000);
            end
            if (i == 39) begin
                chk("ramp.valid_lat2", 32'(out_valid), 32'd1);
                chk("ramp.first", out_data, 32'h41F80000);
            end
            if (i == 40) chk("ramp.hold", out_data, 32'h41F80000);
        end
        chk("ramp.nan", 32'(nan_cnt), 32'd0);
        for (int k = 0; k < 8; k++) expv[k] = i2f(31 + k);
        drain(8, 1'b0, "ramp");
        chk("ramp.peak_held", peak, 32'h42180000);

        // Sign/NaN mix with backpressure on readback.
        expv[0] = 32'hC0A00000;
        expv[1] = 32'h7FC00000;
        expv[2] = 32'h40000000;
        expv[3] = 32'hFFC00001;
        do_start((AW + 1)'(4));
        for (int k = 0; k < SKIP; k++) feed(32'h7F000000);
        for (int k = 0; k < 4; k++) feed(expv[k]);
        step();
        chk("mix.peak", peak, 32'h40A00000);
        chk("mix.nan", 32'(nan_cnt), 32'd2);
        drain(4, 1'b1, "mix");

        // len 0 and len above DEPTH both clamp to DEPTH; start mid-capture ignored.
        run_block((AW + 1)'(0), 100, 16, 1'b0, "len0");
        run_block((AW + 1)'(20), 200, 16, 1'b1, "len20");

        // Reset mid-capture, after Inf and NaN have been recorded.
        do_start((AW + 1)'(8));
        for (int k = 0; k < SKIP; k++) feed(32'h3F800000);
        feed(32'h41100000);
        feed(32'hFF800000);
        feed(32'h7F800001);
        chk("inf.peak", peak, 32'h7F800000);
        chk("inf.nan", 32'(nan_cnt), 32'd1);
        chk("inf.busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.peak", peak, 32'd0);
        chk("abort.nan", 32'(nan_cnt), 32'd0);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.out_data", out_data, 32'd0);
        chk("abort.out_last", 32'(out_last), 32'd0);
        step();
        run_block((AW + 1)'(3), 50, 3, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
